// File: rtl/ni_packetizer_pkg.sv
// ============================================================================
//  Module      : ni_packetizer_pkg
//  Description : Flit type codes, field layout, FSM states and parity helper
//                shared by the network-interface packetizer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ni_packetizer_pkg;

    localparam int FLIT_W  = 32;
    localparam int LEN_W   = 12;
    localparam int PL_W    = 28;
    localparam int ID_W    = 8;
    localparam int ADDR_W  = 4;

    localparam logic [2:0] FLIT_HEADER = 3'b001;
    localparam logic [2:0] FLIT_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;

    localparam int TYPE_MSB = 31;
    localparam int TYPE_LSB = 29;
    localparam int LEN_MSB  = 28;
    localparam int LEN_LSB  = 17;
    localparam int DST_MSB  = 16;
    localparam int DST_LSB  = 13;
    localparam int SRC_MSB  = 12;
    localparam int SRC_LSB  = 9;
    localparam int ID_MSB   = 8;
    localparam int ID_LSB   = 1;
    localparam int PAR_BIT  = 0;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_e;

    // Appends an even-parity bit so that the XOR over the whole flit is zero.
    function automatic logic [FLIT_W-1:0] add_parity(input logic [FLIT_W-2:0] bits);
        return {bits, ^bits};
    endfunction

    function automatic logic [FLIT_W-1:0] build_header(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] dst,
        input logic [ADDR_W-1:0] src,
        input logic [ID_W-1:0]   id
    );
        return add_parity({FLIT_HEADER, len, dst, src, id});
    endfunction

    function automatic logic [FLIT_W-1:0] build_payload(
        input logic            last,
        input logic [PL_W-1:0] data
    );
        return add_parity({(last ? FLIT_TAIL : FLIT_BODY), data});
    endfunction

endpackage

`default_nettype wire

// File: rtl/ni_packetizer.sv
// ============================================================================
//  Module      : ni_packetizer
//  Description : NI transmit stage: turns a descriptor plus payload words into
//                header/body/tail flits streamed under the RTS/CTS handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ni_packetizer
    import ni_packetizer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int AXIS        = 4,
    parameter int MAX_PAYLOAD = 4094
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXIS-1:0]       cur_addr,
    input  logic                  pkt_valid,
    output logic                  pkt_ready,
    input  logic [AXIS-1:0]       pkt_dst,
    input  logic [LEN_W-1:0]      pkt_len,
    input  logic                  pl_valid,
    output logic                  pl_ready,
    input  logic [PL_W-1:0]       pl_data,
    output logic [DATA_WIDTH-1:0] TX,
    output logic                  RTS,
    input  logic                  DCTS,
    output logic                  busy,
    output logic                  err_len
);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   out_flit_q, out_flit_d;
    logic                    out_valid_q, out_valid_d;
    logic [LEN_W-1:0]        rem_q, rem_d;
    logic [ID_W-1:0]         pkt_id_q, pkt_id_d;
    logic                    err_len_q, err_len_d;

    logic                    w_fire;
    logic                    w_slot_free;
    logic                    w_len_ok;
    logic                    w_pkt_ready;
    logic                    w_pl_ready;

    assign w_fire      = out_valid_q & DCTS;
    assign w_slot_free = ~out_valid_q | w_fire;
    assign w_len_ok    = (pkt_len != '0) && (pkt_len <= LEN_W'(MAX_PAYLOAD));

    always_comb begin
        state_d     = state_q;
        out_flit_d  = out_flit_q;
        out_valid_d = out_valid_q & ~w_fire;
        rem_d       = rem_q;
        pkt_id_d    = pkt_id_q;
        err_len_d   = 1'b0;
        w_pkt_ready = 1'b0;
        w_pl_ready  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                w_pkt_ready = w_slot_free;
                if (pkt_valid && w_slot_free) begin
                    if (w_len_ok) begin
                        out_flit_d  = build_header(pkt_len + LEN_W'(1), pkt_dst, cur_addr, pkt_id_q);
                        out_valid_d = 1'b1;
                        rem_d       = pkt_len;
                        pkt_id_d    = pkt_id_q + ID_W'(1);
                        state_d     = ST_PAYLOAD;
                    end else begin
                        // Bad descriptor is consumed so the core is never stalled by it.
                        err_len_d = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                w_pl_ready = w_slot_free;
                if (pl_valid && w_slot_free) begin
                    out_flit_d  = build_payload(rem_q <= LEN_W'(1), pl_data);
                    out_valid_d = 1'b1;
                    rem_d       = (rem_q != '0) ? rem_q - LEN_W'(1) : rem_q;
                    if (rem_q <= LEN_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            out_flit_q  <= '0;
            out_valid_q <= 1'b0;
            rem_q       <= '0;
            pkt_id_q    <= '0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_flit_q  <= out_flit_d;
            out_valid_q <= out_valid_d;
            rem_q       <= rem_d;
            pkt_id_q    <= pkt_id_d;
            err_len_q   <= err_len_d;
        end
    end

    // Ready strobes are masked so every output reads 0 while reset is held.
    assign pkt_ready = rst & w_pkt_ready;
    assign pl_ready  = rst & w_pl_ready;
    assign TX        = out_flit_q;
    assign RTS       = w_fire;
    assign busy      = (state_q != ST_IDLE) | out_valid_q;
    assign err_len   = err_len_q;

endmodule

`default_nettype wire
